// File: rtl/riscv_pkg.sv
// Shared core constants and the fetch buffer payload type.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Small circular instruction buffer of {instr, pc} with push, pop and flush.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wdata,
  output fetch_entry_t                 rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A push into a full buffer is legal only when the head leaves in the same cycle.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != CNT_W'(DEPTH)) | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, one-deep in-flight tracking, redirect kill,
// and a small decoupling buffer toward decode.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);
  localparam int CNT_W = $clog2(BUF_DEPTH+1);
  localparam logic [31:0] PC0 = RESET_PC & ~32'h3;

  logic [XLEN-1:0] pc, inflight_pc, last_pc;
  logic            inflight, kill;
  logic            push, pop;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occ;
  fetch_entry_t    head, wentry;
  logic            unused_lo;

  assign unused_lo = ^redirect_pc[1:0];

  // Requests are throttled so that every response always has a buffer slot.
  always_comb begin
    pop      = id_valid & id_ready & ~redirect_valid;
    occ      = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    imem_req = ~rst & ~redirect_valid & (occ < (CNT_W+1)'(BUF_DEPTH));
    push     = inflight & ~kill & ~redirect_valid;
  end

  assign wentry      = '{instr: imem_rdata, pc: inflight_pc};
  assign imem_addr   = pc;
  assign id_valid    = (count != '0);
  assign id_instr    = id_valid ? head.instr : NOP_INSTR;
  assign id_pc       = id_valid ? head.pc : last_pc;
  assign id_pc_plus4 = id_pc + 32'd4;

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= PC0;
      inflight    <= 1'b0;
      inflight_pc <= PC0;
      kill        <= 1'b0;
      last_pc     <= PC0;
    end else begin
      // Kill covers the response slot right after a redirect that found a request outstanding.
      kill     <= redirect_valid & inflight;
      inflight <= imem_req;
      if (imem_req) inflight_pc <= pc;
      if (redirect_valid)  pc <= {redirect_pc[31:2], 2'b00};
      else if (imem_req)   pc <= pc + 32'd4;
      if (id_valid) last_pc <= head.pc;
    end
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 2, meaning the instruction buffer entries; only 2 is supported.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 imem_req  out  1  fetch request this cycle.
REQ-006 imem_addr  out  32  word-aligned fetch address; bits [1:0] always 0.
REQ-007 imem_rdata  in  32  instruction for the request of the previous cycle; the memory never stalls.
REQ-008 redirect_valid  in  1  branch/jump redirect from execute.
REQ-009 redirect_pc  in  32  redirect target; bits [1:0] ignored.
REQ-010 id_valid  out  1  buffer head holds a valid instruction.
REQ-011 id_ready  in  1  decode accepts the head; pop = id_valid & id_ready.
REQ-012 id_instr  out  32  head instruction.
REQ-013 id_pc  out  32  head instruction address.
REQ-014 id_pc_plus4  out  32  id_pc + 4, modulo 2^32.

Function
REQ-015 The block SHALL hold a PC register, an in-flight flag with its address, a kill flag, and a 2-entry FIFO of {instr, pc}.
REQ-016 imem_req SHALL be 1 when not in reset, redirect_valid=0, and (count + inflight - pop) < 2; otherwise 0.
REQ-017 imem_addr SHALL equal the PC; on each issued request the PC SHALL advance by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-018 A response SHALL be written to the FIFO in the cycle after its request unless the kill flag is set; there is no bypass, so request at cycle N gives id_valid at N+2 at the earliest.
REQ-019 A FIFO push and pop in the same cycle SHALL both take effect; count is unchanged.
REQ-020 Full FIFO plus id_ready=0 SHALL hold id_valid, id_instr, and id_pc stable and issue no request.
REQ-021 When the FIFO is empty, id_valid SHALL be 0; id_instr SHALL read 32'h0000_0013 (NOP), and id_pc SHALL hold its last value.
REQ-022 redirect_valid=1 SHALL flush the FIFO, set PC to {redirect_pc[31:2],2'b00}, set kill if a request is in flight, and issue no request; any pop in that cycle is void.
REQ-023 Kill SHALL discard exactly one response and then clear; a request issued at redirect_pc (cycle N+1) SHALL give id_valid at N+3.
REQ-024 A redirect on consecutive cycles SHALL make the last target win, and no instruction from an earlier target shall reach id_valid.
REQ-025 Occupancy SHALL satisfy count + inflight <= 2 at all times.

Reset
REQ-026 While rst=1, the block SHALL hold PC=RESET_PC, FIFO empty, inflight=0, kill=0, imem_req=0, id_valid=0, id_instr=NOP, and id_pc=RESET_PC.
REQ-027 In the first cycle after rst falls, the block SHALL issue a request to RESET_PC.
REQ-028 Asserting rst mid-operation SHALL discard any in-flight response immediately.

Structure
REQ-029 The shared package riscv_pkg SHALL hold XLEN=32, NOP_INSTR=32'h0000_0013, and the default RESET_PC.
REQ-030 The FIFO SHALL be a sub-module fetch_buffer: 2 entries, 64-bit payload, push/pop/flush, count output.
REQ-031 The PC, in-flight, and kill logic SHALL stay in fetch_stage.

Verification
REQ-032 Release reset with id_ready=1 and imem returning mem[addr>>2] -> id_pc 0,4,8,... one per cycle from cycle 2, id_pc_plus4 = id_pc+4.
REQ-033 Hold id_ready=0 for 5 cycles after the first valid -> at most 2 buffered; id_pc=0 stable; imem_req=0 once full; on release pcs 0,4,8 are delivered in order with none lost or duplicated.
REQ-034 Redirect to 32'h0000_0103 while a request is in flight -> FIFO flushed; stale response dropped; next id_pc = 32'h0000_0100 at redirect cycle + 3.
REQ-035 Redirect on 2 back-to-back cycles (0x200 then 0x300) -> first delivered id_pc = 0x300; no 0x200 instruction is ever valid.
REQ-036 Redirect to 32'hFFFF_FFF8 with id_ready=1 -> id_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; id_pc_plus4 at FFFF_FFFC = 0.
REQ-037 Assert rst asynchronously mid-stream with a full FIFO -> id_valid=0 and imem_req=0 at once; after release the fetch restarts at RESET_PC.
